// File: rtl/dms_ldo_seq_if.sv
// dms_ldo_seq_if: control and sense bundle between the LDO soft-start
// sequencer and its environment (LDO model, supervisor).
// Optional macro LDO_SEQ_UVLO_EN adds the real-valued supply sense vdd_sense.
interface dms_ldo_seq_if;
  logic       start;
  real        vout_sense;
`ifdef LDO_SEQ_UVLO_EN
  real        vdd_sense;
`endif
  real        vref;
  logic       ldo_en;
  logic       pgood;
  logic       fault;
  logic [2:0] state_o;

`ifdef LDO_SEQ_UVLO_EN
  modport master (output start, output vout_sense, output vdd_sense,
                  input vref, input ldo_en, input pgood, input fault, input state_o);
  modport slave  (input start, input vout_sense, input vdd_sense,
                  output vref, output ldo_en, output pgood, output fault, output state_o);
`else
  modport master (output start, output vout_sense,
                  input vref, input ldo_en, input pgood, input fault, input state_o);
  modport slave  (input start, input vout_sense,
                  output vref, output ldo_en, output pgood, output fault, output state_o);
`endif
endinterface

// File: rtl/dms_ldo_seq.sv
// dms_ldo_seq: soft-start / power-good sequencer for the DMS LDO model.
// Drives a stepped real-valued reference (never accumulated: vref is always
// recomputed from the integer step count) and the LDO enable, then watches
// the sensed output for a settle window and a debounced dropout.
// Optional macro LDO_SEQ_UVLO_EN adds supply under-voltage lockout with
// hysteresis on bus.vdd_sense.
module dms_ldo_seq #(
  parameter real VREF_FINAL  = 1.5,
  parameter real VREF_STEP   = 0.05,
  parameter real SCALE       = 2.0,
  parameter real PG_TOL      = 0.1,
  parameter int  EN_DLY      = 4,
  parameter int  SETTLE_CYC  = 16,
  parameter int  TIMEOUT_CYC = 256,
  parameter int  PG_DEBOUNCE = 3
`ifdef LDO_SEQ_UVLO_EN
  ,
  parameter real UVLO_RISE   = 2.7,
  parameter real UVLO_FALL   = 2.5
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  dms_ldo_seq_if.slave  bus
);

  // Window bounds carry a tiny margin so decimal boundary values that are not
  // exactly representable in binary (2.9, 3.1) still count as inclusive.
  localparam real V_TARGET = VREF_FINAL * SCALE;
  localparam real V_EPS    = 1.0e-9;
  localparam real WIN_LO   = V_TARGET - PG_TOL - V_EPS;
  localparam real WIN_HI   = V_TARGET + PG_TOL + V_EPS;

  // Number of ramp steps = ceil(VREF_FINAL / VREF_STEP).
  localparam int STEP_RND = int'(VREF_FINAL / VREF_STEP);
  localparam int STEP_MAX = ((real'(STEP_RND) * VREF_STEP) < (VREF_FINAL - V_EPS)) ?
                            STEP_RND + 1 : STEP_RND;

  localparam int SW  = $clog2(STEP_MAX + 1);
  localparam int EW  = $clog2(EN_DLY + 1);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int BW  = $clog2(PG_DEBOUNCE + 1);

  localparam logic [SW-1:0]  STEP_FULL   = SW'(STEP_MAX);
  localparam logic [SW-1:0]  STEP_LAST   = SW'(STEP_MAX - 1);
  localparam logic [EW-1:0]  EN_LAST     = EW'(EN_DLY - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0]  DEB_LAST    = BW'(PG_DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_EN_WAIT = 3'd1,
    ST_RAMP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_GOOD    = 3'd4,
    ST_RAMP_DN = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  state_t         state_q, state_d, state_nx_s;
  logic [SW-1:0]  step_q, step_d, step_nx_s;
  logic [EW-1:0]  en_cnt_q, en_cnt_d, en_cnt_nx_s;
  logic [SCW-1:0] settle_q, settle_d, settle_nx_s;
  logic [TW-1:0]  tmo_q, tmo_d, tmo_nx_s;
  logic [BW-1:0]  bad_q, bad_d, bad_nx_s;
  logic           ldo_en_q, ldo_en_d;
  logic           pgood_q, pgood_d;
  logic           fault_q, fault_d;
  real            vref_q, vref_d;
  logic           in_win_s;
  logic           go_ok_s;
  logic           trip_s;

  // States in which the LDO is enabled and the supply is being loaded.
  function automatic logic is_active(input state_t s);
    return (s == ST_EN_WAIT) || (s == ST_RAMP) || (s == ST_SETTLE) ||
           (s == ST_GOOD) || (s == ST_RAMP_DN);
  endfunction

  // Regulation window check; a NaN sense value (real X/Z) fails both compares.
  always_comb begin
    in_win_s = (bus.vout_sense >= WIN_LO) && (bus.vout_sense <= WIN_HI);
  end

`ifdef LDO_SEQ_UVLO_EN
  // Supply lockout with hysteresis; an unknown supply reading trips.
  always_comb begin
    go_ok_s = (bus.vdd_sense >= UVLO_RISE);
    trip_s  = is_active(state_q) && !(bus.vdd_sense >= UVLO_FALL);
  end
`else
  // Supply is assumed present: power-up always allowed, never trips.
  always_comb begin
    go_ok_s = 1'b1;
    trip_s  = 1'b0;
  end
`endif

  // Sequencing decisions and counter updates while staying in a state.
  always_comb begin
    state_nx_s  = state_q;
    step_nx_s   = step_q;
    en_cnt_nx_s = en_cnt_q;
    settle_nx_s = settle_q;
    tmo_nx_s    = tmo_q;
    bad_nx_s    = bad_q;
    case (state_q)
      ST_OFF: begin
        if (bus.start && go_ok_s) state_nx_s = ST_EN_WAIT;
        else                      state_nx_s = ST_OFF;
      end
      ST_EN_WAIT: begin
        en_cnt_nx_s = en_cnt_q + EW'(1);
        if (!bus.start)               state_nx_s = ST_RAMP_DN;
        else if (en_cnt_q == EN_LAST) state_nx_s = ST_RAMP;
        else                          state_nx_s = ST_EN_WAIT;
      end
      ST_RAMP: begin
        if (!bus.start) begin
          state_nx_s = ST_RAMP_DN;
        end else begin
          step_nx_s = step_q + SW'(1);
          if (step_q == STEP_LAST) state_nx_s = ST_SETTLE;
          else                     state_nx_s = ST_RAMP;
        end
      end
      ST_SETTLE: begin
        settle_nx_s = in_win_s ? (settle_q + SCW'(1)) : {SCW{1'b0}};
        tmo_nx_s    = tmo_q + TW'(1);
        // start=0 first, then GOOD before timeout on a same-clock tie.
        if (!bus.start)                            state_nx_s = ST_RAMP_DN;
        else if (in_win_s && settle_q == SETTLE_LAST) state_nx_s = ST_GOOD;
        else if (tmo_q == TMO_LAST)                state_nx_s = ST_FAULT;
        else                                       state_nx_s = ST_SETTLE;
      end
      ST_GOOD: begin
        bad_nx_s = in_win_s ? {BW{1'b0}} : (bad_q + BW'(1));
        if (!bus.start)                        state_nx_s = ST_RAMP_DN;
        else if (!in_win_s && bad_q == DEB_LAST) state_nx_s = ST_FAULT;
        else                                   state_nx_s = ST_GOOD;
      end
      ST_RAMP_DN: begin
        // start is deliberately ignored until the ramp-down completes.
        if (step_q == {SW{1'b0}}) begin
          state_nx_s = ST_OFF;
        end else begin
          step_nx_s  = step_q - SW'(1);
          state_nx_s = ST_RAMP_DN;
        end
      end
      ST_FAULT: begin
        if (!bus.start) state_nx_s = ST_OFF;
        else            state_nx_s = ST_FAULT;
      end
      default: begin
        state_nx_s = ST_OFF;
      end
    endcase
  end

  // Final next state, counter clearing on any transition, and the registered
  // outputs derived from the state being entered.
  always_comb begin
    state_d  = trip_s ? ST_FAULT : state_nx_s;
    en_cnt_d = (state_d == state_q) ? en_cnt_nx_s : {EW{1'b0}};
    settle_d = (state_d == state_q) ? settle_nx_s : {SCW{1'b0}};
    tmo_d    = (state_d == state_q) ? tmo_nx_s    : {TW{1'b0}};
    bad_d    = (state_d == state_q) ? bad_nx_s    : {BW{1'b0}};
    step_d   = ((state_d == ST_OFF) || (state_d == ST_FAULT)) ? {SW{1'b0}} : step_nx_s;
    ldo_en_d = is_active(state_d);
    pgood_d  = (state_d == ST_GOOD);
    fault_d  = (state_d == ST_FAULT);
    vref_d   = (step_d == STEP_FULL) ? VREF_FINAL : (real'(step_d) * VREF_STEP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      step_q   <= {SW{1'b0}};
      en_cnt_q <= {EW{1'b0}};
      settle_q <= {SCW{1'b0}};
      tmo_q    <= {TW{1'b0}};
      bad_q    <= {BW{1'b0}};
      ldo_en_q <= 1'b0;
      pgood_q  <= 1'b0;
      fault_q  <= 1'b0;
      vref_q   <= 0.0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      en_cnt_q <= en_cnt_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      bad_q    <= bad_d;
      ldo_en_q <= ldo_en_d;
      pgood_q  <= pgood_d;
      fault_q  <= fault_d;
      vref_q   <= vref_d;
    end
  end

  assign bus.vref    = vref_q;
  assign bus.ldo_en  = ldo_en_q;
  assign bus.pgood   = pgood_q;
  assign bus.fault   = fault_q;
  assign bus.state_o = state_q;

endmodule
